filter_output_capture: RTL

Sink-side counterpart of the sample-strobe stimulus driver used with the 8-band equalizer `filter`. It regenerates the filter's output-valid strobe (ce_out) by delaying the input sample strobe through a clock-enable-gated delay line matched to filter latency. It captures filter_out on each ce_out into a FIFO and drains it over a valid/ready stream. It counts captured samples and raises done after a programmed number.

---
 rtl/filter_output_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/filter_output_capture.sv
// filter_output_capture: sink-side capture for the 8-band equalizer filter.
// Rebuilds the filter's output-valid strobe by delaying the input sample
// strobe through a clock-enable-gated shift register, captures filter_out
// into a first-word-fall-through FIFO on each regenerated strobe, drains it
// over a valid/ready stream, and counts captures up to a programmed limit.
//
// Stream handshake: m_valid is high whenever the FIFO holds a sample and
// m_data then shows the oldest one; a transfer happens on every rising edge
// where m_valid and m_ready are both high, and m_data is held while
// m_valid=1 and m_ready=0.
module filter_output_capture #(
    parameter int DATA_BITS   = 16,
    parameter int LATENCY     = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_BITS   = 4,
    parameter int MAX_SAMPLES = 2000,
    parameter int COUNT_BITS  = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_enable,
    input  logic                        sample_strobe,
    input  logic signed [DATA_BITS-1:0] filter_out,
    output logic                        ce_out,
    output logic signed [DATA_BITS-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [ADDR_BITS:0]          fifo_count,
    output logic                        overflow,
    output logic [COUNT_BITS-1:0]       sample_count,
    output logic                        done
);

    localparam logic [ADDR_BITS:0]    DEPTH_C = (ADDR_BITS+1)'(FIFO_DEPTH);
    localparam logic [COUNT_BITS-1:0] MAX_C   = COUNT_BITS'(MAX_SAMPLES);

    logic [LATENCY-1:0]    stage_q, stage_d;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [COUNT_BITS-1:0] scount_q, scount_d;
    logic                  done_q, done_d;

    logic full;
    logic pop;
    logic push_ok;

    // Strobe emerges LATENCY enabled edges after it was sampled; stops after done.
    assign ce_out  = stage_q[LATENCY-1] & clk_enable & ~done_q;

    assign m_valid = (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign pop     = m_valid & m_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok = ce_out & (~full | pop);

    assign m_data       = m_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign sample_count = scount_q;
    assign done         = done_q;

    // Next-state for delay line, pointers, occupancy and capture bookkeeping.
    always_comb begin
        stage_d    = stage_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        scount_d   = scount_q;
        done_d     = done_q;

        if (clk_enable) begin
            stage_d[0] = sample_strobe;
            for (int i = 1; i < LATENCY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
            2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
            default: count_d = count_q;
        endcase

        if (ce_out && !push_ok) begin
            overflow_d = 1'b1;
        end

        // Every emitted strobe counts, captured or dropped; never past the limit.
        if (ce_out && (scount_q < MAX_C)) begin
            scount_d = scount_q + COUNT_BITS'(1);
        end
        if (scount_d == MAX_C) begin
            done_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            scount_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            scount_q   <= scount_d;
            done_q     <= done_d;
        end
    end

    // Sample storage; contents are only observable through m_data while m_valid=1.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= filter_out;
        end
    end

endmodule
